// File: rtl/md_unit_if.sv
// Request/response bundle between the decode/GRF side and the multiply/divide unit.
// Ports: start/MDUOp/A/B flow toward the unit; busy/done/HI/LO/MDOut flow back.
// master = requester (datapath control), slave = md_unit.
interface md_unit_if;
  logic        start;
  logic [3:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDOut;

  modport master (
    output start, MDUOp, A, B,
    input  busy, done, HI, LO, MDOut
  );

  modport slave (
    input  start, MDUOp, A, B,
    output busy, done, HI, LO, MDOut
  );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle MIPS multiply/divide unit holding the HI/LO architectural registers.
// Latency: MULT* commit MULT_CYCLES edges after the start edge, DIV* after DIV_CYCLES; MT*/MF* act at once.
// Backpressure: busy is high while an op is in flight and every start is ignored then.
// Ports: clk, reset (async, active-low), bus (md_unit_if.slave: start/MDUOp/A/B in, busy/done/HI/LO/MDOut out).
// Optional: define MDU_MADD_EN to add MADD/MADDU/MSUB/MSUBU (ops 9-12); otherwise 9-15 are no-ops.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic     clk,
  input  logic     reset,
  md_unit_if.slave bus
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  typedef enum logic { S_IDLE = 1'b0, S_BUSY = 1'b1 } state_t;
  // How the pending 64-bit value is applied to {HI,LO} at commit.
  typedef enum logic [1:0] { M_SET, M_KEEP, M_ADD, M_SUB } mode_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [63:0]     pend;
  mode_t           pend_mode;
  logic [31:0]     hi_q, lo_q;
  logic            done_q;

  logic [63:0]     prod_s, prod_u, res;
  logic [31:0]     dvs, quo_s, rem_s, quo_u, rem_u;
  logic            is_md, launch, commit;
  mode_t           mode;
  logic [CW-1:0]   n_ld;

  // Result datapath, evaluated on the live operands and captured at the start edge.
  always_comb begin
    prod_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
    prod_u = {32'd0, bus.A} * {32'd0, bus.B};
    // Divide-by-zero result is discarded (M_KEEP); substitute 1 so the divider never sees zero.
    dvs    = (bus.B == 32'd0) ? 32'd1 : bus.B;
    quo_u  = bus.A / dvs;
    rem_u  = bus.A % dvs;
    if (bus.A == 32'h8000_0000 && dvs == 32'hFFFF_FFFF) begin
      quo_s = 32'h8000_0000;
      rem_s = 32'd0;
    end else begin
      quo_s = $signed(bus.A) / $signed(dvs);
      rem_s = $signed(bus.A) % $signed(dvs);
    end

    is_md = 1'b0;
    res   = prod_u;
    mode  = M_SET;
    n_ld  = CW'(MULT_CYCLES);
    case (bus.MDUOp)
      OP_MULT:  begin is_md = 1'b1; res = prod_s; end
      OP_MULTU: begin is_md = 1'b1; res = prod_u; end
      OP_DIV: begin
        is_md = 1'b1;
        res   = {rem_s, quo_s};
        n_ld  = CW'(DIV_CYCLES);
        mode  = (bus.B == 32'd0) ? M_KEEP : M_SET;
      end
      OP_DIVU: begin
        is_md = 1'b1;
        res   = {rem_u, quo_u};
        n_ld  = CW'(DIV_CYCLES);
        mode  = (bus.B == 32'd0) ? M_KEEP : M_SET;
      end
`ifdef MDU_MADD_EN
      OP_MADD:  begin is_md = 1'b1; res = prod_s; mode = M_ADD; end
      OP_MADDU: begin is_md = 1'b1; res = prod_u; mode = M_ADD; end
      OP_MSUB:  begin is_md = 1'b1; res = prod_s; mode = M_SUB; end
      OP_MSUBU: begin is_md = 1'b1; res = prod_u; mode = M_SUB; end
`endif
      default: ;
    endcase
  end

  assign launch = (state == S_IDLE) && bus.start && is_md;
  // cnt is loaded with N at the start edge, so the Nth following edge sees cnt==1.
  assign commit = (state == S_BUSY) && (cnt == CW'(1));

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (launch) state_nxt = S_BUSY;
      S_BUSY:  if (commit) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.busy = (state == S_BUSY);
    bus.done = done_q;
    bus.HI   = hi_q;
    bus.LO   = lo_q;
    case (bus.MDUOp)
      OP_MFHI: bus.MDOut = hi_q;
      OP_MFLO: bus.MDOut = lo_q;
      default: bus.MDOut = 32'd0;
    endcase
  end

  // Counter, pending result and HI/LO registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      pend      <= 64'd0;
      pend_mode <= M_KEEP;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      done_q <= commit;
      if (launch) begin
        cnt       <= n_ld;
        pend      <= res;
        pend_mode <= mode;
      end else if (state == S_BUSY) begin
        cnt <= cnt - CW'(1);
      end
      if (commit) begin
        // Accumulate modes read {HI,LO} here, at commit, not at start.
        case (pend_mode)
          M_SET:   {hi_q, lo_q} <= pend;
          M_ADD:   {hi_q, lo_q} <= {hi_q, lo_q} + pend;
          M_SUB:   {hi_q, lo_q} <= {hi_q, lo_q} - pend;
          default: ;
        endcase
      end else if (state == S_IDLE && bus.start) begin
        if (bus.MDUOp == OP_MTHI) hi_q <= bus.A;
        if (bus.MDUOp == OP_MTLO) lo_q <= bus.A;
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases then randomized ops against a reference model.
// Model computes results with 64-bit integer arithmetic and tracks the architectural HI/LO.
// Checks busy length, the single done pulse, HI/LO, MDOut and async reset abort.
module tb_md_unit;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  md_unit_if bus ();

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          md;
    int          n;
    bit          we;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural effect of one start request issued while idle.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    longint sp, sq, sr;
    longint unsigned up, uq, ur;
    logic [63:0] v;
    e.md = 0; e.n = 0; e.we = 0; e.hi = hi; e.lo = lo;
    sp = longint'($signed(a)) * longint'($signed(b));
    up = longint'(a) * longint'(b);
    case (op)
      4'd1: begin e.md = 1; e.n = MC; e.we = 1; v = sp; e.hi = v[63:32]; e.lo = v[31:0]; end
      4'd2: begin e.md = 1; e.n = MC; e.we = 1; v = up; e.hi = v[63:32]; e.lo = v[31:0]; end
      4'd3: begin
        e.md = 1; e.n = DC;
        if (b != 0) begin
          sq = longint'($signed(a)) / longint'($signed(b));
          sr = longint'($signed(a)) % longint'($signed(b));
          e.we = 1; v = sq; e.lo = v[31:0]; v = sr; e.hi = v[31:0];
        end
      end
      4'd4: begin
        e.md = 1; e.n = DC;
        if (b != 0) begin
          uq = longint'(a) / longint'(b);
          ur = longint'(a) % longint'(b);
          e.we = 1; v = uq; e.lo = v[31:0]; v = ur; e.hi = v[31:0];
        end
      end
      4'd7: begin e.we = 1; e.hi = a; end
      4'd8: begin e.we = 1; e.lo = a; end
`ifdef MDU_MADD_EN
      4'd9, 4'd10, 4'd11, 4'd12: begin
        e.md = 1; e.n = MC; e.we = 1;
        v = (op == 4'd9 || op == 4'd11) ? sp : up;
        if (op <= 4'd10) v = {hi, lo} + v;
        else             v = {hi, lo} - v;
        e.hi = v[63:32]; e.lo = v[31:0];
      end
`endif
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rnd_operand();
    logic [31:0] sp [5];
    sp[0] = 32'd0; sp[1] = 32'h8000_0000; sp[2] = 32'hFFFF_FFFF; sp[3] = 32'd1; sp[4] = 32'h7FFF_FFFF;
    if ($urandom_range(3) == 0) return sp[$urandom_range(4)];
    return $urandom();
  endfunction

  // Issue one op at the coming edge and follow it to completion. Called just after a negedge.
  // While busy, start is held high with junk (MTHI first) which must be ignored.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   bc;
    e = model(op, a, b, m_hi, m_lo);
    bus.start = 1'b1; bus.MDUOp = op; bus.A = a; bus.B = b;
    @(negedge clk);
    bc = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus.busy) break;
      bc++;
      bus.start = 1'b1;
      bus.MDUOp = (i == 0) ? 4'd7 : 4'($urandom_range(15));
      bus.A = $urandom(); bus.B = $urandom();
      @(negedge clk);
    end
    bus.start = 1'b0; bus.MDUOp = 4'd0; bus.A = $urandom(); bus.B = $urandom();
    check({tag, ".busy_cycles"}, 64'(bc), 64'(e.n));
    check({tag, ".done"}, 64'(bus.done), 64'(e.md));
    if (e.we) begin m_hi = e.hi; m_lo = e.lo; end
    check({tag, ".hilo"}, {bus.HI, bus.LO}, {m_hi, m_lo});
    @(negedge clk);
    check({tag, ".done_clr"}, 64'(bus.done), 64'd0);
    bus.MDUOp = 4'd5; #1;
    check({tag, ".mfhi"}, 64'(bus.MDOut), 64'(m_hi));
    bus.MDUOp = 4'd6; #1;
    check({tag, ".mflo"}, 64'(bus.MDOut), 64'(m_lo));
    bus.MDUOp = 4'd0; #1;
    check({tag, ".mdout0"}, 64'(bus.MDOut), 64'd0);
  endtask

  initial begin
    int dn;
    bus.start = 1'b0; bus.MDUOp = 4'd0; bus.A = 32'd0; bus.B = 32'd0;
    repeat (3) @(negedge clk);
    check("rst.busy", 64'(bus.busy), 64'd0);
    check("rst.done", 64'(bus.done), 64'd0);
    check("rst.hilo", {bus.HI, bus.LO}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    run_op("mult_neg1x2",  4'd1, 32'hFFFF_FFFF, 32'd2);
    run_op("multu_max_x2", 4'd2, 32'hFFFF_FFFF, 32'd2);
    run_op("div_m7_2",     4'd3, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_by0",     4'd4, 32'd7, 32'd0);
    run_op("div_ovf",      4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("mthi_idle",    4'd7, 32'h0000_1234, 32'd0);
    run_op("mtlo_idle",    4'd8, 32'hFFFF_FFFF, 32'd0);
    run_op("mthi_zero",    4'd7, 32'd0, 32'd0);
    run_op("maddu_1x1",    4'd10, 32'd1, 32'd1);
    run_op("reserved15",   4'd15, 32'hDEAD_BEEF, 32'd3);
    run_op("none_op",      4'd0, 32'h1111_1111, 32'd3);

    for (int k = 0; k < 70; k++) begin
      logic [3:0] op;
      op = ($urandom_range(2) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(1, 4));
      run_op($sformatf("rnd%0d_op%0d", k, op), op, rnd_operand(), rnd_operand());
    end

    // Async reset in the middle of a divide aborts it with no trailing done.
    run_op("pre_rst_mthi", 4'd7, 32'hA5A5_0001, 32'd0);
    bus.start = 1'b1; bus.MDUOp = 4'd3; bus.A = 32'd100; bus.B = 32'd7;
    @(negedge clk);
    bus.start = 1'b0; bus.MDUOp = 4'd0;
    repeat (2) @(negedge clk);
    check("abort.busy_before", 64'(bus.busy), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("abort.busy", 64'(bus.busy), 64'd0);
    check("abort.hilo", {bus.HI, bus.LO}, 64'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    dn = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dn++;
    end
    check("abort.no_done", 64'(dn), 64'd0);
    check("abort.hilo_after", {bus.HI, bus.LO}, 64'd0);
    run_op("post_rst_mult", 4'd1, 32'd3, 32'hFFFF_FFFE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
